// File: rtl/z80fi_mcycle_recorder_if.sv
// rtl/z80fi_mcycle_recorder_if.sv - core cycle strobes in, per-instruction formal record out
interface z80fi_mcycle_recorder_if #(
    parameter int TCYC_W = 4
) ();
    logic              tstate;
    logic              mcycle_start;
    logic [2:0]        mcycle_type;
    logic              insn_start;
    logic              insn_end;
    logic              opcode_valid;
    logic [7:0]        opcode_byte;
    logic              mem_rd;
    logic              mem_wr;
    logic [15:0]       mem_addr;
    logic [7:0]        mem_data;

    logic              z80fi_valid;
    logic [31:0]       z80fi_insn;
    logic [2:0]        z80fi_insn_len;
    logic [2:0]        z80fi_mcycle_type1, z80fi_mcycle_type2, z80fi_mcycle_type3, z80fi_mcycle_type4;
    logic [2:0]        z80fi_mcycle_type5, z80fi_mcycle_type6, z80fi_mcycle_type7, z80fi_mcycle_type8;
    logic [TCYC_W-1:0] z80fi_tcycles1, z80fi_tcycles2, z80fi_tcycles3, z80fi_tcycles4;
    logic [TCYC_W-1:0] z80fi_tcycles5, z80fi_tcycles6, z80fi_tcycles7, z80fi_tcycles8;
    logic [15:0]       z80fi_bus_raddr;
    logic [7:0]        z80fi_bus_rdata;
    logic [15:0]       z80fi_bus_waddr;
    logic [7:0]        z80fi_bus_wdata;
    logic              z80fi_overflow;

    modport master (
        output tstate, mcycle_start, mcycle_type, insn_start, insn_end,
               opcode_valid, opcode_byte, mem_rd, mem_wr, mem_addr, mem_data,
        input  z80fi_valid, z80fi_insn, z80fi_insn_len,
               z80fi_mcycle_type1, z80fi_mcycle_type2, z80fi_mcycle_type3, z80fi_mcycle_type4,
               z80fi_mcycle_type5, z80fi_mcycle_type6, z80fi_mcycle_type7, z80fi_mcycle_type8,
               z80fi_tcycles1, z80fi_tcycles2, z80fi_tcycles3, z80fi_tcycles4,
               z80fi_tcycles5, z80fi_tcycles6, z80fi_tcycles7, z80fi_tcycles8,
               z80fi_bus_raddr, z80fi_bus_rdata, z80fi_bus_waddr, z80fi_bus_wdata, z80fi_overflow
    );

    modport slave (
        input  tstate, mcycle_start, mcycle_type, insn_start, insn_end,
               opcode_valid, opcode_byte, mem_rd, mem_wr, mem_addr, mem_data,
        output z80fi_valid, z80fi_insn, z80fi_insn_len,
               z80fi_mcycle_type1, z80fi_mcycle_type2, z80fi_mcycle_type3, z80fi_mcycle_type4,
               z80fi_mcycle_type5, z80fi_mcycle_type6, z80fi_mcycle_type7, z80fi_mcycle_type8,
               z80fi_tcycles1, z80fi_tcycles2, z80fi_tcycles3, z80fi_tcycles4,
               z80fi_tcycles5, z80fi_tcycles6, z80fi_tcycles7, z80fi_tcycles8,
               z80fi_bus_raddr, z80fi_bus_rdata, z80fi_bus_waddr, z80fi_bus_wdata, z80fi_overflow
    );
endinterface

// File: rtl/z80fi_mcycle_recorder.sv
// rtl/z80fi_mcycle_recorder.sv - builds one formal record per retired instruction from core cycle strobes
module z80fi_mcycle_recorder #(
    parameter int MAX_MCYCLES = 8,
    parameter int TCYC_W      = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    z80fi_mcycle_recorder_if.slave bus
);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;
    localparam logic [2:0] CYCLE_NONE = 3'd0;

    typedef struct packed {
        logic [MAX_MCYCLES-1:0][2:0]        mt;
        logic [MAX_MCYCLES-1:0][TCYC_W-1:0] tc;
        logic [3:0]                         idx;   // slots in use; MAX_MCYCLES+1 once overflowed
        logic [2:0]                         len;
        logic [31:0]                        insn;
        logic [15:0]                        raddr;
        logic [7:0]                         rdata;
        logic                               rcap;
        logic [15:0]                        waddr;
        logic [7:0]                         wdata;
        logic                               wcap;
        logic                               ovf;
    } rec_t;

    typedef struct packed {
        logic [MAX_MCYCLES-1:0][2:0]        mt;
        logic [MAX_MCYCLES-1:0][TCYC_W-1:0] tc;
        logic [2:0]                         len;
        logic [31:0]                        insn;
        logic [15:0]                        raddr;
        logic [7:0]                         rdata;
        logic [15:0]                        waddr;
        logic [7:0]                         wdata;
        logic                               ovf;
    } out_t;

    logic [0:0] state_q, state_d;
    rec_t       work_q, work_d;
    out_t       out_q, out_d;
    logic       valid_q, valid_d;
    rec_t       fresh, timed, tgt;
    logic       start_new;
    logic [2:0] last_slot;

    always_comb begin
        start_new = bus.insn_start & bus.mcycle_start;
        last_slot = work_q.idx[2:0] - 3'd1;

        fresh = '0;
        for (int i = 0; i < MAX_MCYCLES; i++) fresh.mt[i] = CYCLE_NONE;
        fresh.idx   = 4'd1;
        fresh.mt[0] = bus.mcycle_type;
        fresh.tc[0] = {{(TCYC_W-1){1'b0}}, bus.tstate};

        // The clk that opens a new record never advances or counts in the old one.
        timed = work_q;
        if (bus.mcycle_start && !bus.insn_start) begin
            if (work_q.idx < 4'(MAX_MCYCLES)) begin
                timed.mt[work_q.idx[2:0]] = bus.mcycle_type;
                timed.tc[work_q.idx[2:0]] = TCYC_W'(1);
                timed.idx                 = work_q.idx + 4'd1;
            end else begin
                timed.idx = 4'(MAX_MCYCLES + 1);
                timed.ovf = 1'b1;
            end
        end else if (bus.tstate && !bus.mcycle_start && work_q.idx != 4'd0 &&
                     work_q.idx <= 4'(MAX_MCYCLES)) begin
            if (work_q.tc[last_slot] != {TCYC_W{1'b1}})
                timed.tc[last_slot] = work_q.tc[last_slot] + TCYC_W'(1);
        end

        // Strobes belong to the closing record on insn_end, otherwise to the one being built.
        tgt = (start_new && !bus.insn_end) ? fresh : timed;
        if (bus.opcode_valid) begin
            if (tgt.len < 3'd4) begin
                tgt.insn[{tgt.len[1:0], 3'b000} +: 8] = bus.opcode_byte;
                tgt.len = tgt.len + 3'd1;
            end else begin
                tgt.ovf = 1'b1;
            end
        end
        if (bus.mem_rd && !tgt.rcap) begin
            tgt.raddr = bus.mem_addr;
            tgt.rdata = bus.mem_data;
            tgt.rcap  = 1'b1;
        end
        if (bus.mem_wr && !tgt.wcap) begin
            tgt.waddr = bus.mem_addr;
            tgt.wdata = bus.mem_data;
            tgt.wcap  = 1'b1;
        end

        state_d = state_q;
        work_d  = work_q;
        out_d   = out_q;
        valid_d = 1'b0;
        if (state_q == ST_COLLECT && bus.insn_end) begin
            valid_d     = 1'b1;
            out_d.mt    = tgt.mt;
            out_d.tc    = tgt.tc;
            out_d.len   = tgt.len;
            out_d.insn  = tgt.insn;
            out_d.raddr = tgt.raddr;
            out_d.rdata = tgt.rdata;
            out_d.waddr = tgt.waddr;
            out_d.wdata = tgt.wdata;
            out_d.ovf   = tgt.ovf;
        end
        if (start_new) begin
            state_d = ST_COLLECT;
            work_d  = bus.insn_end ? fresh : tgt;
        end else if (state_q == ST_COLLECT) begin
            if (bus.insn_end) state_d = ST_IDLE;
            else              work_d  = tgt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign bus.z80fi_valid        = valid_q;
    assign bus.z80fi_insn         = out_q.insn;
    assign bus.z80fi_insn_len     = out_q.len;
    assign bus.z80fi_mcycle_type1 = out_q.mt[0];
    assign bus.z80fi_mcycle_type2 = out_q.mt[1];
    assign bus.z80fi_mcycle_type3 = out_q.mt[2];
    assign bus.z80fi_mcycle_type4 = out_q.mt[3];
    assign bus.z80fi_mcycle_type5 = out_q.mt[4];
    assign bus.z80fi_mcycle_type6 = out_q.mt[5];
    assign bus.z80fi_mcycle_type7 = out_q.mt[6];
    assign bus.z80fi_mcycle_type8 = out_q.mt[7];
    assign bus.z80fi_tcycles1     = out_q.tc[0];
    assign bus.z80fi_tcycles2     = out_q.tc[1];
    assign bus.z80fi_tcycles3     = out_q.tc[2];
    assign bus.z80fi_tcycles4     = out_q.tc[3];
    assign bus.z80fi_tcycles5     = out_q.tc[4];
    assign bus.z80fi_tcycles6     = out_q.tc[5];
    assign bus.z80fi_tcycles7     = out_q.tc[6];
    assign bus.z80fi_tcycles8     = out_q.tc[7];
    assign bus.z80fi_bus_raddr    = out_q.raddr;
    assign bus.z80fi_bus_rdata    = out_q.rdata;
    assign bus.z80fi_bus_waddr    = out_q.waddr;
    assign bus.z80fi_bus_wdata    = out_q.wdata;
    assign bus.z80fi_overflow     = out_q.ovf;
endmodule

// File: doc/z80fi_mcycle_recorder.md
# z80fi_mcycle_recorder

Builds the per-instruction formal record (`z80fi_valid`, instruction bytes and length, machine-cycle types, T-state counts, first memory read/write) from the core's cycle-level strobes. It sits between the Z80 core and the `z80fi_insn_spec_*` checkers. Each checker compares its `spec_*` outputs against the record this block produces. One record is emitted per retired instruction; a repeating block instruction (LDIR/LDDR/CPIR...) emits one record per iteration.

## Interface
Parameters:
- MAX_MCYCLES, 8, number of machine-cycle slots recorded (fixed; slots 1..8)
- TCYC_W, 4, width of each T-state count

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- tstate  in  1  high for one clk per T-state of the core
- mcycle_start  in  1  qualifies tstate; first T-state of a machine cycle
- mcycle_type  in  3  `CYCLE_*` code of the cycle, valid with mcycle_start
- insn_start  in  1  with mcycle_start; first M1 of a new instruction
- insn_end  in  1  with tstate; last T-state of the instruction
- opcode_valid  in  1  pulse; an instruction byte was fetched
- opcode_byte  in  8  fetched byte
- mem_rd / mem_wr  in  1  pulse; data memory read/write completed
- mem_addr  in  16  address for mem_rd/mem_wr
- mem_data  in  8  data for mem_rd/mem_wr
- z80fi_valid  out  1  record valid, one-clk pulse
- z80fi_insn  out  32  bytes in fetch order, first byte in [7:0]
- z80fi_insn_len  out  3  bytes fetched, 0..4
- z80fi_mcycle_type1..8  out  3 each  `CYCLE_*` per slot, `CYCLE_NONE` if unused
- z80fi_tcycles1..8  out  TCYC_W each  T-states per slot, 0 if unused
- z80fi_bus_raddr / z80fi_bus_rdata  out  16 / 8  first data read
- z80fi_bus_waddr / z80fi_bus_wdata  out  16 / 8  first data write
- z80fi_overflow  out  1  record truncated (>8 mcycles or >4 bytes)

## Operation
- State machine:
  - IDLE: entered at reset. Waits for insn_start.
  - COLLECT: accumulates the working record.
  - COLLECT with insn_end: copies the working record to the output registers, then returns to IDLE, or stays in COLLECT if insn_start arrives in the same clk.
- insn_start (with mcycle_start) clears the working record:
  - all slots set to `CYCLE_NONE`/0; len, captured flags and overflow set to 0.
  - slot index = 1; type1 = mcycle_type; tcycles1 = 1 if tstate.
- Each later mcycle_start: slot index + 1. The new slot gets mcycle_type and a T count of 1. At index 9 and beyond, overflow is set and data is dropped.
- Each tstate that is not an mcycle_start: the current slot's count + 1, saturating at 2^TCYC_W−1. Saturation does not set overflow.
- opcode_valid: byte stored at byte lane len; len + 1. A 5th byte sets overflow and is dropped; len stays 4.
- Bus capture:
  - first mem_rd latches raddr/rdata; first mem_wr latches waddr/wdata; later accesses are ignored.
  - Uncaptured fields output 0.
- Strobes in IDLE (no insn_start) are ignored.
- insn_start while in COLLECT without insn_end discards the partial record and sets no output.

## Timing
- Reset: every output is 0. All mcycle_type outputs are `CYCLE_NONE`. State is IDLE.
- z80fi_valid rises on the clk after the clk carrying insn_end and lasts exactly 1 clk. The record outputs update on that same edge and hold until the next valid.
- insn_end's own tstate is counted before the record is copied. Strobes in the insn_end clk (opcode_valid, mem_rd/mem_wr) are included in the record.
- insn_end together with insn_start: the record closes and the new one opens in the same clk, with no lost T-state. The new insn_start cycle belongs only to the new record.
- Minimum spacing is back-to-back insn_end every clk. The block never stalls and has no backpressure.
- reset_n asserted mid-instruction: the record is abandoned and z80fi_valid is not pulsed.

## Test plan
- NOP: M1 of 4 T-states, byte 0x00, insn_end on T4 -> valid once, 1 clk later:
  - insn_len=1, insn[7:0]=0x00, type1=`CYCLE_M1`, tcycles1=4;
  - slots 2..8 `CYCLE_NONE`/0.
- LDDR iteration with BC=2, HL=0x1234→0x55, DE=0x2000:
  - 7 mcycles: M1/4, M1/4, RDWR/3, RDWR/3, EXT/1, EXT/1, INT/5;
  - bytes 0xED 0xB8 -> insn[15:0]=0xB8ED, len=2, raddr=0x1234, rdata=0x55, waddr=0x2000, wdata=0x55, types/tcycles as listed, type8=`CYCLE_NONE`.
- Back-to-back: insn_end and the next insn_start in the same clk -> two valid pulses. The second record's tcycles1 counts from the shared clk.
- Overflow: 10 mcycles and 5 opcode bytes -> slots 1..8 filled, len=4, z80fi_overflow=1. One slot held 20 T-states -> that tcycles reads 15.
- reset_n low during mcycle 3, then released, then a NOP -> no valid during or after the reset until the NOP's record; outputs read 0 while reset is low.
- Two mem_rd and two mem_wr in one instruction -> only the first address/data of each is reported.
